// File: rtl/irq_priority_controller_pkg.sv
// irq_priority_controller_pkg: shared defaults for the interrupt controller slice
package irq_priority_controller_pkg;
    localparam int DEFAULT_N = 16;
endpackage

// File: rtl/irq_priority_controller_if.sv
// irq_priority_controller_if: interrupt sources, enable CSR and claim/complete handshake
interface irq_priority_controller_if import irq_priority_controller_pkg::*; #(
    parameter int N = DEFAULT_N
);
    localparam int W = $clog2(N);
    logic [N-1:0] irq_i;
    logic         enable_we_i;
    logic [N-1:0] enable_data_i;
    logic         claim_i;
    logic         complete_i;
    logic [W-1:0] complete_id_i;
    logic         ext_irq_o;
    logic         claim_valid_o;
    logic         claim_none_o;
    logic [W-1:0] claim_id_o;
    logic [N-1:0] pending_o;
    logic [N-1:0] enable_o;
    modport master (
        output irq_i, enable_we_i, enable_data_i, claim_i, complete_i, complete_id_i,
        input  ext_irq_o, claim_valid_o, claim_none_o, claim_id_o, pending_o, enable_o
    );
    modport slave (
        input  irq_i, enable_we_i, enable_data_i, claim_i, complete_i, complete_id_i,
        output ext_irq_o, claim_valid_o, claim_none_o, claim_id_o, pending_o, enable_o
    );
endinterface

// File: rtl/irq_priority_controller_priority_encoder.sv
// priority_encoder: index of the most significant set bit (0 when nothing is set)
module priority_encoder #(
    parameter int N = 16
) (
    input  logic [N-1:0]         a,
    output logic [$clog2(N)-1:0] y
);
    localparam int W = $clog2(N);
    // Later (higher) indices overwrite earlier ones, so the top set bit wins
    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++)
            if (a[i]) y = W'(i);
    end
endmodule

// File: rtl/irq_priority_controller.sv
// irq_priority_controller: edge-latched pending/enable interrupt controller with claim/complete handshake
module irq_priority_controller import irq_priority_controller_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input logic clock,
    input logic reset,
    irq_priority_controller_if.slave bus
);
    localparam int W = $clog2(N);
    typedef enum logic {IDLE, SERVING} state_t;
    state_t state, state_next;
    logic [N-1:0] pending, enable, irq_prev, eligible, rise, clr;
    logic [W-1:0] sel_id, claim_id, claim_id_next;
    logic any, grant, claim_valid, claim_none, claim_none_next;

    assign rise     = bus.irq_i & ~irq_prev;
    assign eligible = pending & enable;
    assign any      = |eligible;

    priority_encoder #(.N(N)) u_enc (.a(eligible), .y(sel_id));

    // Next state, pending-clear mask and claim response contents
    always_comb begin
        grant           = (state == IDLE) && bus.claim_i && any;
        clr             = grant ? ({{(N-1){1'b0}}, 1'b1} << sel_id) : '0;
        state_next      = state;
        if (state == IDLE)
            state_next = grant ? SERVING : IDLE;
        else if (bus.complete_i && bus.complete_id_i == claim_id)
            state_next = IDLE;
        claim_none_next = bus.claim_i && !grant;
        claim_id_next   = grant ? sel_id : (bus.claim_i && state == IDLE) ? '0 : claim_id;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Edge capture, pending/enable registers and registered claim response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_prev    <= '0;
            pending     <= '0;
            enable      <= '0;
            claim_valid <= 1'b0;
            claim_none  <= 1'b0;
            claim_id    <= '0;
        end else begin
            irq_prev    <= bus.irq_i;
            pending     <= (pending & ~clr) | rise;
            if (bus.enable_we_i) enable <= bus.enable_data_i;
            claim_valid <= bus.claim_i;
            claim_none  <= claim_none_next;
            claim_id    <= claim_id_next;
        end
    end

    assign bus.ext_irq_o     = (state == IDLE) && any;
    assign bus.claim_valid_o = claim_valid;
    assign bus.claim_none_o  = claim_none;
    assign bus.claim_id_o    = claim_id;
    assign bus.pending_o     = pending;
    assign bus.enable_o      = enable;
endmodule

// File: doc/irq_priority_controller.md
Name: irq_priority_controller

Overview:
- Single-context external interrupt controller for the core.
- Latches rising edges on N interrupt sources into a pending register and masks them with a software-written enable register.
- Selects the highest-index pending and enabled source through a priority encoder.
- Runs a claim/complete handshake with the trap logic, so only one source is in service at a time.

Parameters:
N, 16, number of interrupt sources (N >= 2); W = $clog2(N) is a derived localparam for the ID width.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
irq_i  input  N  interrupt source lines, already synchronous to clock; level, edge-detected internally
enable_we_i  input  1  write strobe for the enable register
enable_data_i  input  N  new enable mask, written when enable_we_i=1
claim_i  input  1  single-cycle claim request from the trap handler
complete_i  input  1  single-cycle completion notice
complete_id_i  input  W  ID being completed
ext_irq_o  output  1  interrupt request to the core
claim_valid_o  output  1  one-cycle pulse: claim response valid
claim_none_o  output  1  qualifies claim_valid_o: no source was eligible
claim_id_o  output  W  claimed source ID, held until the next claim response
pending_o  output  N  pending register, for CSR readback
enable_o  output  N  enable register, for CSR readback

Behaviour:
- Reset values, applied asynchronously: pending, enable, irq_prev, claim_valid_o, claim_none_o, claim_id_o and ext_irq_o all 0; state IDLE.
- Edge detect: irq_prev <= irq_i every cycle; rise = irq_i & ~irq_prev.
- Pending update: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of the claimed ID in the claim cycle, else 0.
  - A rise on the same bit in the same cycle wins, so the bit stays 1.
- Enable: enable <= enable_data_i when enable_we_i. Takes effect on arbitration from the next cycle. Disabling a source does not clear its pending bit.
- eligible = pending & enable.
- Priority encoder selects sel_id = index of the most significant set bit of eligible; any = |eligible.
- FSM states: IDLE, SERVING.
- IDLE:
  - ext_irq_o = any (combinational from registers, no added latency).
  - claim_i with any=1: clear pending[sel_id] and register claim_id_o = sel_id. Next cycle claim_valid_o = 1 and claim_none_o = 0. State moves to SERVING.
  - claim_i with any=0: next cycle claim_valid_o = 1, claim_none_o = 1, claim_id_o = 0. State stays IDLE.
  - Claim latency is 1 cycle.
- SERVING:
  - ext_irq_o = 0; arbitration is frozen.
  - Edges still set pending, including for the in-service ID.
  - claim_i: response is claim_valid_o = 1, claim_none_o = 1 next cycle; no state change.
  - complete_i with complete_id_i == claim_id_o: move to IDLE next cycle.
  - complete_i with any other ID: ignored.
- complete_i in IDLE: ignored.
- claim_i and complete_i in the same cycle:
  - In SERVING, complete is processed and claim is answered claim_none_o = 1.
  - In IDLE, claim is processed and complete is ignored.
- claim_valid_o and claim_none_o are single-cycle pulses; both are 0 in any cycle with no response.
- Reset mid-service: everything returns to reset values immediately. Edges already captured are lost.
- Edges on an already-pending bit merge; there is no counting.

Decomposition:
- No new package types needed.
- W is computed locally with $clog2.
- State enum {IDLE, SERVING} stays inside the module.
- Instantiate the existing priority_encoder (N) as the single sub-module, with A = eligible and Y = sel_id.
- Derive any separately, because Y = 0 for both an empty input and bit 0 alone.

Test Plan:
- Reset then idle:
  - Assert reset mid-cycle -> all outputs 0 immediately (asynchronous).
  - Release, enable = 16'hFFFF, irq_i = 0 -> ext_irq_o stays 0.
- Priority:
  - Enable 16'hFFFF; pulse irq_i bits 3, 9 and 0 simultaneously -> ext_irq_o = 1.
  - claim -> claim_id_o = 9, claim_none_o = 0, pending_o = 16'h0009.
- Serve sequence:
  - complete 9 -> IDLE, ext_irq_o = 1.
  - claim -> 3; complete 3; claim -> 0; complete 0.
  - Final claim -> claim_none_o = 1, claim_id_o = 0.
- Masking:
  - enable = 16'h0001, pending bits 5 and 0 -> claim returns 0; pending_o keeps bit 5.
  - enable = 16'hFFFF after completing 0 -> ext_irq_o = 1, next claim returns 5.
- SERVING rules:
  - While serving 7: complete 4 -> ignored, stays SERVING.
  - Second claim -> claim_none_o = 1.
  - New edge on bit 7 -> pending_o[7] = 1.
  - complete 7 -> ext_irq_o = 1 next cycle, claim returns 7.
- Collision: edge on bit 2 in the same cycle as the claim of 2 -> pending_o[2] remains 1 after the claim.
